// File: rtl/calc_pkg.sv
// Shared definitions for the calculator input sequencer: FSM encoding, operation
// codes and the default operation count.
package calc_pkg;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StEnterA     = 3'd1,
        StSelectOp   = 3'd2,
        StEnterB     = 3'd3,
        StShowAnswer = 3'd4
    } seq_state_e;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpMul = 3'd2;
    localparam logic [2:0] OpDiv = 3'd3;
    localparam logic [2:0] OpAnd = 3'd4;
    localparam logic [2:0] OpOr  = 3'd5;

    localparam int unsigned DefaultNumOps = 6;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw button, debounces it and emits a one-cycle pulse on each
// accepted press (rising edge of the accepted level).
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press
);

    localparam int unsigned CntWidth = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);

    logic [1:0]          sync_q;
    logic [CntWidth-1:0] cnt_q;
    logic                level_q;
    logic                level_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b00;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press        <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], button};
            level_prev_q <= level_q;
            press        <= level_q & ~level_prev_q;
            // Any cycle agreeing with the accepted level restarts the count.
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/calc_input_sequencer.sv
// Walks the user through operand A, operation select and operand B using three
// debounced buttons, then pulses calc_start when the answer stage is entered.
module calc_input_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned NUM_OPS         = DefaultNumOps
) (
    input  logic        IN_clk,
    input  logic        IN_rst_n,
    input  logic [15:0] IN_switches,
    input  logic        IN_center_button,
    input  logic        IN_up_button,
    input  logic        IN_down_button,
    output logic [15:0] OUT_operand_a,
    output logic [15:0] OUT_operand_b,
    output logic [2:0]  OUT_operation_code,
    output logic        OUT_show_16bit_input,
    output logic        OUT_show_operation,
    output logic        OUT_show_answer,
    output logic        OUT_calc_start
);

    localparam logic [2:0] CodeMax = 3'(NUM_OPS - 1);

    logic center_press;
    logic up_press;
    logic down_press;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_center_db (
        .clk    (IN_clk),
        .rst_n  (IN_rst_n),
        .button (IN_center_button),
        .press  (center_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
        .clk    (IN_clk),
        .rst_n  (IN_rst_n),
        .button (IN_up_button),
        .press  (up_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
        .clk    (IN_clk),
        .rst_n  (IN_rst_n),
        .button (IN_down_button),
        .press  (down_press)
    );

    seq_state_e state_q;

    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            state_q              <= StIdle;
            OUT_operand_a        <= 16'h0000;
            OUT_operand_b        <= 16'h0000;
            OUT_operation_code   <= OpAdd;
            OUT_show_16bit_input <= 1'b0;
            OUT_show_operation   <= 1'b0;
            OUT_show_answer      <= 1'b0;
            OUT_calc_start       <= 1'b0;
        end else begin
            OUT_calc_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (center_press) begin
                        state_q              <= StEnterA;
                        OUT_show_16bit_input <= 1'b1;
                    end
                end
                StEnterA: begin
                    if (center_press) begin
                        state_q              <= StSelectOp;
                        OUT_operand_a        <= IN_switches;
                        OUT_show_16bit_input <= 1'b0;
                        OUT_show_operation   <= 1'b1;
                    end
                end
                StSelectOp: begin
                    // Center wins over up/down; simultaneous up and down cancel.
                    if (center_press) begin
                        state_q              <= StEnterB;
                        OUT_show_operation   <= 1'b0;
                        OUT_show_16bit_input <= 1'b1;
                    end else if (up_press && !down_press) begin
                        OUT_operation_code <= (OUT_operation_code >= CodeMax) ? 3'd0
                                                                              : OUT_operation_code + 3'd1;
                    end else if (down_press && !up_press) begin
                        OUT_operation_code <= (OUT_operation_code == 3'd0) ? CodeMax
                                                                           : OUT_operation_code - 3'd1;
                    end
                end
                StEnterB: begin
                    if (center_press) begin
                        state_q              <= StShowAnswer;
                        OUT_operand_b        <= IN_switches;
                        OUT_show_16bit_input <= 1'b0;
                        OUT_show_answer      <= 1'b1;
                        OUT_calc_start       <= 1'b1;
                    end
                end
                StShowAnswer: begin
                    if (center_press) begin
                        state_q         <= StIdle;
                        OUT_show_answer <= 1'b0;
                    end
                end
                default: begin
                    state_q              <= StIdle;
                    OUT_show_16bit_input <= 1'b0;
                    OUT_show_operation   <= 1'b0;
                    OUT_show_answer      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Directed bench for calc_input_sequencer with a short debounce window.
module tb_calc_input_sequencer;

    localparam int unsigned Deb = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] switches;
    logic        center;
    logic        up;
    logic        down;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [2:0]  op_code;
    logic        show_in;
    logic        show_op;
    logic        show_ans;
    logic        calc_start;

    int vectors;
    int miscompares;
    int start_seen;
    logic watch;

    calc_input_sequencer #(.DEBOUNCE_CYCLES(Deb), .NUM_OPS(6)) dut (
        .IN_clk               (clk),
        .IN_rst_n             (rst_n),
        .IN_switches          (switches),
        .IN_center_button     (center),
        .IN_up_button         (up),
        .IN_down_button       (down),
        .OUT_operand_a        (operand_a),
        .OUT_operand_b        (operand_b),
        .OUT_operation_code   (op_code),
        .OUT_show_16bit_input (show_in),
        .OUT_show_operation   (show_op),
        .OUT_show_answer      (show_ans),
        .OUT_calc_start       (calc_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch && calc_start) start_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive buttons and wait until the resulting state update is visible.
    task automatic hit(input logic c, input logic u, input logic d);
        center = c;
        up     = u;
        down   = d;
        repeat (Deb + 4) @(negedge clk);
    endtask

    task automatic release_all();
        center = 1'b0;
        up     = 1'b0;
        down   = 1'b0;
        repeat (Deb + 4) @(negedge clk);
    endtask

    task automatic tap(input logic c, input logic u, input logic d);
        hit(c, u, d);
        release_all();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        start_seen  = 0;
        watch       = 1'b0;
        rst_n       = 1'b0;
        switches    = 16'h0000;
        center      = 1'b0;
        up          = 1'b0;
        down        = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_shows", {show_in, show_op, show_ans, calc_start}, 4'b0000);
        chk("reset_code", op_code, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean press: event on edge 7, state change on edge 8.
        center = 1'b1;
        repeat (6) @(negedge clk);
        chk("clean_no_event_edge6", dut.center_press, 1'b0);
        @(negedge clk);
        chk("clean_event_edge7", dut.center_press, 1'b1);
        chk("clean_still_idle", show_in, 1'b0);
        @(negedge clk);
        chk("enter_a_show_in", {show_in, show_op, show_ans}, 3'b100);
        chk("clean_event_one_cycle", dut.center_press, 1'b0);
        release_all();

        // Bounce 1,0,1,1...: count restarts, event on edge 9.
        switches = 16'h1234;
        center = 1'b1;
        @(negedge clk);
        center = 1'b0;
        @(negedge clk);
        center = 1'b1;
        repeat (6) @(negedge clk);
        chk("bounce_no_event_edge8", dut.center_press, 1'b0);
        chk("bounce_still_enter_a", show_in, 1'b1);
        @(negedge clk);
        chk("bounce_event_edge9", dut.center_press, 1'b1);
        @(negedge clk);
        chk("select_op_show", {show_in, show_op, show_ans}, 3'b010);
        chk("operand_a", operand_a, 16'h1234);
        repeat (20) @(negedge clk);
        chk("held_single_event", {show_in, show_op, show_ans}, 3'b010);
        release_all();

        tap(1'b0, 1'b1, 1'b0);
        tap(1'b0, 1'b1, 1'b0);
        tap(1'b0, 1'b1, 1'b0);
        chk("three_ups", op_code, 3'd3);
        tap(1'b1, 1'b0, 1'b0);
        chk("enter_b_show", {show_in, show_op, show_ans}, 3'b100);
        chk("no_start_in_enter_b", calc_start, 1'b0);
        switches = 16'h00FF;
        hit(1'b1, 1'b0, 1'b0);
        chk("calc_start_first_cycle", calc_start, 1'b1);
        chk("show_answer", {show_in, show_op, show_ans}, 3'b001);
        chk("operand_b", operand_b, 16'h00FF);
        @(negedge clk);
        chk("calc_start_one_cycle", calc_start, 1'b0);
        release_all();
        tap(1'b0, 1'b1, 1'b0);
        chk("up_ignored_in_answer", op_code, 3'd3);

        // Second pass: code is kept across IDLE.
        switches = 16'h1234;
        tap(1'b1, 1'b0, 1'b0);
        chk("idle_shows", {show_in, show_op, show_ans}, 3'b000);
        chk("idle_holds_code", op_code, 3'd3);
        chk("idle_holds_a", operand_a, 16'h1234);
        tap(1'b1, 1'b0, 1'b0);
        tap(1'b1, 1'b0, 1'b0);
        chk("pass2_select_op", show_op, 1'b1);
        tap(1'b0, 1'b0, 1'b1);
        tap(1'b0, 1'b0, 1'b1);
        tap(1'b0, 1'b0, 1'b1);
        chk("down_to_zero", op_code, 3'd0);
        tap(1'b0, 1'b0, 1'b1);
        chk("down_wraps_to_5", op_code, 3'd5);
        tap(1'b0, 1'b1, 1'b0);
        chk("up_wraps_to_0", op_code, 3'd0);
        tap(1'b0, 1'b1, 1'b1);
        chk("up_down_cancel", op_code, 3'd0);
        tap(1'b0, 1'b1, 1'b0);
        tap(1'b0, 1'b1, 1'b0);
        chk("up_twice_to_2", op_code, 3'd2);
        tap(1'b1, 1'b1, 1'b0);
        chk("center_wins_state", {show_in, show_op, show_ans}, 3'b100);
        chk("center_wins_code", op_code, 3'd2);
        tap(1'b0, 1'b1, 1'b0);
        chk("up_outside_select", op_code, 3'd2);

        // Asynchronous reset in ENTER_B, center held through release.
        #2;
        rst_n  = 1'b0;
        center = 1'b1;
        #1;
        chk("async_rst_a", operand_a, 16'h0000);
        chk("async_rst_b", operand_b, 16'h0000);
        chk("async_rst_code", op_code, 3'd0);
        chk("async_rst_flags", {show_in, show_op, show_ans, calc_start}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        watch = 1'b1;
        repeat (Deb + 3) @(negedge clk);
        chk("held_through_reset_wait", show_in, 1'b0);
        @(negedge clk);
        chk("held_through_reset_event", show_in, 1'b1);
        release_all();
        repeat (10) @(negedge clk);
        chk("no_start_after_reset", start_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_input_sequencer.md
CALC_INPUT_SEQUENCER -- requirements
Module: calc_input_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles before a button level is accepted.
REQ-002 Parameter NUM_OPS, default 6, meaning number of valid operation codes, 0..NUM_OPS-1, NUM_OPS<=8.
REQ-003 IN_clk  input  1  system clock; the block has one clock.
REQ-004 IN_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 IN_switches  input  16  raw board switches, operand source.
REQ-006 IN_center_button, IN_up_button, IN_down_button  input  1 each  raw asynchronous board buttons.
REQ-007 OUT_operand_a, OUT_operand_b  output  16 each  captured operands.
REQ-008 OUT_operation_code  output  3  selected operation.
REQ-009 OUT_show_16bit_input, OUT_show_operation, OUT_show_answer  output  1 each  display stage select, at most one high.
REQ-010 OUT_calc_start  output  1  one-cycle pulse: operands and code valid for calculation.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose accepted level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-012 A press event SHALL be a one-cycle pulse on a 0->1 change of the accepted level; release SHALL produce no event; a held button SHALL produce exactly one event.
REQ-013 A clean raw rising edge SHALL produce its press event exactly DEBOUNCE_CYCLES+3 clock edges after the first edge sampling it high.
REQ-014 FSM states: IDLE, ENTER_A, SELECT_OP, ENTER_B, SHOW_ANSWER; all transitions on center press event only.
REQ-015 IDLE: all show outputs 0; center -> ENTER_A.
REQ-016 ENTER_A: OUT_show_16bit_input=1; center -> capture IN_switches into OUT_operand_a, go SELECT_OP.
REQ-017 SELECT_OP: OUT_show_operation=1; up event increments code, NUM_OPS-1 wraps to 0; down decrements, 0 wraps to NUM_OPS-1; center -> ENTER_B.
REQ-018 ENTER_B: OUT_show_16bit_input=1; center -> capture IN_switches into OUT_operand_b, go SHOW_ANSWER.
REQ-019 OUT_calc_start SHALL be high exactly in the first cycle of SHOW_ANSWER, never otherwise.
REQ-020 SHOW_ANSWER: OUT_show_answer=1; up/down ignored here; center -> IDLE; operands and code held.
REQ-021 Show outputs SHALL be registered, decoded from state, changing on the same edge as the state.
REQ-022 Up and down events in the same cycle SHALL leave the code unchanged.
REQ-023 Center and up/down in the same cycle: center wins; state advances, code unchanged.
REQ-024 Up/down events outside SELECT_OP SHALL not alter the code.
REQ-025 Operands, code SHALL hold their values until overwritten in the next pass; code is not cleared on IDLE.

Reset
REQ-026 IN_rst_n low SHALL immediately force IDLE, operands 0, code 0, all show outputs 0, OUT_calc_start 0, debouncer counters and accepted levels 0.
REQ-027 Reset mid-sequence SHALL abandon the pass; no OUT_calc_start pulse follows release.
REQ-028 A button held through reset release SHALL generate a press event after debounce (accepted level restarts at 0).

Structure
REQ-029 Package calc_pkg SHALL hold state encoding, op code constants (ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5) and default NUM_OPS.
REQ-030 Synchronizer, debounce counter and edge detector SHALL be sub-module button_debouncer, instantiated three times.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Clean center press after reset -> event exactly 7 edges later; state ENTER_A, OUT_show_16bit_input=1.
REQ-032 Center bouncing 1,0,1,1 -> no event until 4 stable cycles; exactly one event per hold.
REQ-033 Full pass: A=16'h1234, three up events, B=16'h00FF -> operand_a=1234, code=3, operand_b=00FF, calc_start one cycle, OUT_show_answer=1.
REQ-034 SELECT_OP at code 0, one down -> 5; at 5, one up -> 0; up+down same cycle -> unchanged.
REQ-035 IN_rst_n asserted in ENTER_B -> all outputs 0 asynchronously, no calc_start after release.
REQ-036 Center+up same cycle in SELECT_OP code 2 -> ENTER_B, code 2.
